fft_frame_feeder: RTL and testbench

- Streams the recorder's captured audio out of recorder sample memory into the xfft_1 AXI-Stream slave input as fixed-length frames.
- Generates tlast on every FRAME_LEN-th beat and zero-pads the final partial frame.
- Honours tready backpressure using a small prefetch FIFO that hides the memory read latency.
- Replaces the ad-hoc fft_valid/fft_last logic between recorder and FFT.

---
 rtl/fft_frame_feeder_if.sv | 14 +
 rtl/fft_frame_feeder.sv | 185 ++++++++++++++++++
 tb/tb_fft_frame_feeder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_feeder_if.sv
// AXI-Stream link from the frame feeder to the FFT slave input.
//   tdata  : {16'h0000 imaginary, 16-bit real part}
//   tvalid : source holds a beat
//   tlast  : last beat of an FFT frame
//   tready : sink accepts the beat
interface fft_frame_feeder_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/fft_frame_feeder.sv
// Streams recorded samples from sample memory into the FFT as fixed-length
// frames, zero-padding the final partial frame and asserting tlast on every
// FRAME_LEN-th beat. A small prefetch FIFO hides the memory read latency so
// that, with tready held high, one beat per cycle leaves the block.
//
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   start_in           start pulse (accepted only in IDLE)
//   sample_count_in    number of valid samples, latched at start
//   mem_addr_out       sample memory read address
//   mem_data_in        sample data, MEM_LATENCY cycles after its address
//   m_axis             AXI-Stream master towards the FFT
//   busy_out           high from start acceptance until the final handshake
//   done_out           one-cycle pulse after the final beat is accepted
//   frame_count_out    frames fully transferred since the last start
module fft_frame_feeder #(
  parameter int unsigned FRAME_LEN    = 1024,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [ADDR_WIDTH-1:0]   sample_count_in,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  input  logic [SAMPLE_WIDTH-1:0] mem_data_in,
  fft_frame_feeder_if.master      m_axis,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [15:0]             frame_count_out
);

  localparam int unsigned CW  = ADDR_WIDTH + 1;
  localparam int unsigned FLB = $clog2(FRAME_LEN);
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned UW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                  state_q;
  logic [CW-1:0]           n_q, t_q, rd_cnt_q, beat_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [MEM_LATENCY:0]    pipe_v_q, pipe_z_q;
  logic [MEM_LATENCY:0]    pipe_v_d, pipe_z_d;
  logic [SAMPLE_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [UW-1:0]           fifo_cnt_q, used_q;
  logic [SAMPLE_WIDTH-1:0] out_q;
  logic                    out_v_q, out_last_q;
  logic                    busy_q, done_q;
  logic [15:0]             frames_q;

  logic                    hs, issue, pad, cap, out_free, pop, load_byp, push;
  logic                    last_next;
  logic [SAMPLE_WIDTH-1:0] cap_data;
  logic [CW-1:0]           beat_cnt_d, n_start, t_start;
  logic [PW-1:0]           wr_ptr_inc, rd_ptr_inc;

  always_comb begin
    hs         = out_v_q & m_axis.tready;
    // Credits cover FIFO entries, the output register and reads still in the
    // delay line; a beat leaving this cycle frees its credit immediately so a
    // full pipeline can keep issuing one read per cycle.
    issue      = (state_q == STREAM) && (rd_cnt_q < t_q) &&
                 ((used_q != UW'(FIFO_DEPTH)) || hs);
    pad        = !(rd_cnt_q < n_q);
    cap        = pipe_v_q[MEM_LATENCY];
    cap_data   = pipe_z_q[MEM_LATENCY] ? '0 : mem_data_in;
    beat_cnt_d = beat_cnt_q + CW'(hs);
    out_free   = !out_v_q || hs;
    pop        = out_free && (fifo_cnt_q != '0);
    // Empty FIFO: the arriving sample goes straight to the output register.
    load_byp   = out_free && (fifo_cnt_q == '0) && cap;
    push       = cap && !load_byp;
    last_next  = (beat_cnt_d[FLB-1:0] == '1);
    n_start    = {1'b0, sample_count_in};
    t_start    = (n_start + CW'(FRAME_LEN - 1)) & ~CW'(FRAME_LEN - 1);
    wr_ptr_inc = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_inc = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    pipe_v_d    = '0;
    pipe_z_d    = '0;
    pipe_v_d[0] = issue;
    pipe_z_d[0] = issue && pad;
    for (int unsigned i = 1; i <= MEM_LATENCY; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_z_d[i] = pipe_z_q[i-1];
    end
  end

  // Storage needs no reset; occupancy is tracked by the reset pointers.
  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr_q] <= cap_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      n_q        <= '0;
      t_q        <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      pipe_v_q   <= '0;
      pipe_z_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      used_q     <= '0;
      out_q      <= '0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frames_q   <= '0;
    end else begin
      pipe_v_q   <= pipe_v_d;
      pipe_z_q   <= pipe_z_d;
      used_q     <= used_q + UW'(issue) - UW'(hs);
      fifo_cnt_q <= fifo_cnt_q + UW'(push) - UW'(pop);
      beat_cnt_q <= beat_cnt_d;
      done_q     <= 1'b0;

      if (issue) begin
        rd_cnt_q <= rd_cnt_q + CW'(1);
        if (!pad) addr_q <= rd_cnt_q[ADDR_WIDTH-1:0];
      end
      if (push) wr_ptr_q <= wr_ptr_inc;

      if (pop) begin
        out_q      <= fifo_q[rd_ptr_q];
        out_v_q    <= 1'b1;
        out_last_q <= last_next;
        rd_ptr_q   <= rd_ptr_inc;
      end else if (load_byp) begin
        out_q      <= cap_data;
        out_v_q    <= 1'b1;
        out_last_q <= last_next;
      end else if (out_free) begin
        out_v_q    <= 1'b0;
        out_last_q <= 1'b0;
      end

      if (hs && out_last_q) frames_q <= frames_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (start_in) begin
            n_q        <= n_start;
            t_q        <= t_start;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            frames_q   <= '0;
            if (sample_count_in == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= STREAM;
              busy_q  <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (beat_cnt_d == t_q) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_out     = addr_q;
  assign m_axis.tdata     = {16'h0000, out_q, {(16 - SAMPLE_WIDTH){1'b0}}};
  assign m_axis.tvalid    = out_v_q;
  assign m_axis.tlast     = out_last_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign frame_count_out  = frames_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: expected beats are queued when a
// start is driven and popped on every observed handshake.
module tb_fft_frame_feeder;
  localparam int FL = 8;
  localparam int SW = 8;
  localparam int AW = 8;
  localparam int ML = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cnt_in = '0;
  logic [AW-1:0] addr;
  logic [SW-1:0] mdata;
  logic [SW-1:0] d1;
  logic          busy, done;
  logic [15:0]   frames;

  fft_frame_feeder_if bus ();

  fft_frame_feeder #(
    .FRAME_LEN(FL), .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW),
    .MEM_LATENCY(ML), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .sample_count_in(cnt_in), .mem_addr_out(addr), .mem_data_in(mdata),
    .m_axis(bus), .busy_out(busy), .done_out(done),
    .frame_count_out(frames)
  );

  always #5 clk = ~clk;

  // Memory model: word i holds i+1, two-cycle read pipeline.
  always @(posedge clk) begin
    d1    <= addr + 8'd1;
    mdata <= d1;
  end

  typedef struct packed { logic [7:0] s; logic l; } exp_t;
  exp_t sb[$];

  int unsigned vectors = 0, miscompares = 0;
  int          cyc = 0, rdy_pct = 100;
  int          first_valid_cyc, last_hs_cyc, done_cyc, done_pulses;
  int          beats, max_addr, max_out;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // One cycle: pick tready for the coming edge, then observe the outputs.
  task automatic tick();
    exp_t e;
    int   o;
    @(negedge clk);
    cyc++;
    bus.tready = ($urandom_range(0, 99) < rdy_pct);
    if (prev_stall) begin
      check("stall_valid", {31'd0, bus.tvalid}, 1);
      check("stall_data", bus.tdata, prev_data);
      check("stall_last", {31'd0, bus.tlast}, {31'd0, prev_last});
    end
    if (bus.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) begin
      done_cyc = cyc;
      done_pulses++;
    end
    if (busy) begin
      if (int'(addr) > max_addr) max_addr = int'(addr);
      o = int'(addr) + 1 - beats;
      if (o > max_out) max_out = o;
    end
    if (bus.tvalid && bus.tready) begin
      beats++;
      last_hs_cyc = cyc;
      if (sb.size() == 0) begin
        check("extra_beat", beats, beats - 1);
      end else begin
        e = sb.pop_front();
        check("tdata", bus.tdata, {16'h0000, e.s, 8'h00});
        check("tlast", {31'd0, bus.tlast}, {31'd0, e.l});
      end
    end
    prev_stall = bus.tvalid && !bus.tready;
    prev_data  = bus.tdata;
    prev_last  = bus.tlast;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic clear_mon();
    beats = 0; first_valid_cyc = -1; done_pulses = 0; done_cyc = -1;
    last_hs_cyc = -1; max_addr = 0; max_out = 0;
  endtask

  task automatic push_exp(input int n, output int t);
    exp_t e;
    t = ((n + FL - 1) / FL) * FL;
    for (int i = 0; i < t; i++) begin
      e.s = (i < n) ? 8'(i + 1) : 8'h00;
      e.l = ((i % FL) == FL - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run(input int n, input int pct, input bit rst_first, input bit poke);
    int t, st;
    if (rst_first) do_reset();
    rdy_pct = pct;
    clear_mon();
    sb.delete();
    push_exp(n, t);
    cnt_in = AW'(n);
    start  = 1'b1;
    st     = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3000 && done_pulses == 0; k++) begin
      tick();
      if (poke && beats == 3) begin
        start  = 1'b1;
        cnt_in = AW'(5);
      end else begin
        start = 1'b0;
      end
    end
    check("done_seen", done_pulses, 1);
    // Start coincident with the done pulse must be ignored.
    start  = 1'b1;
    cnt_in = AW'(n);
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("busy_idle", {31'd0, busy}, 0);
    check("done_once", done_pulses, 1);
    check("beats", beats, t);
    check("sb_empty", sb.size(), 0);
    check("frames", {16'd0, frames}, t / FL);
    if (n == 0) begin
      check("done_lat0", done_cyc - st, 1);
      check("no_valid", first_valid_cyc, -1);
    end else begin
      // Edge sampling start is one tick before the first observation.
      if (pct == 100) check("latency", first_valid_cyc - st, ML + 3);
      check("done_lat", done_cyc - last_hs_cyc, 1);
      check("max_addr", max_addr, n - 1);
      check("outstanding", {31'd0, max_out <= FD}, 1);
    end
  endtask

  initial begin
    bus.tready = 1'b0;
    clear_mon();
    do_reset();
    check("rst_tvalid", {31'd0, bus.tvalid}, 0);
    check("rst_tlast", {31'd0, bus.tlast}, 0);
    check("rst_tdata", bus.tdata, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_addr", {24'd0, addr}, 0);
    check("rst_frames", {16'd0, frames}, 0);

    run(16, 100, 1'b1, 1'b0);
    run(11, 100, 1'b1, 1'b0);
    run(16, 30, 1'b1, 1'b0);
    run(0, 100, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the first frame.
    do_reset();
    rdy_pct = 100;
    clear_mon();
    sb.delete();
    begin
      int t;
      push_exp(16, t);
    end
    cnt_in = AW'(16);
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && beats < 5; k++) tick();
    check("reach_beat5", beats, 5);
    #2 rst = 1'b1;
    #1;
    check("arst_tvalid", {31'd0, bus.tvalid}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_addr", {24'd0, addr}, 0);
    tick();
    rst = 1'b0;
    prev_stall = 1'b0;
    run(8, 100, 1'b0, 1'b0);

    run(16, 100, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
